operand_shifter: RTL and testbench

Iterative shifter for operand B, feeding the ALU's `B` and `carry` inputs. It applies LSL, LSR, ASR, ROR, RRX and immediate-rotate to a 32-bit value, shifting one bit position per clock. It produces the shifted result and a shifter carry-out with ARM semantics. A start/done handshake lets the datapath controller stall the execute stage until the operand is ready.

---
 rtl/shifter_pkg.sv | 40 ++++
 rtl/operand_shifter_if.sv | 26 ++
 rtl/operand_shifter_shift_step.sv | 32 +++
 rtl/operand_shifter.sv | 168 ++++++++++++++++
 tb/tb_operand_shifter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the operand shifter: shift-type codes,
// FSM state encoding, step-count clamps and the shift-type decoder.
package shifter_pkg;

  typedef enum logic [2:0] {
    SH_LSL     = 3'b000,
    SH_LSR     = 3'b001,
    SH_ASR     = 3'b010,
    SH_ROR     = 3'b011,
    SH_RRX     = 3'b100,
    SH_IMM_ROT = 3'b101
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // LSL/LSR/ASR saturate at 33 steps: one past the word width, so the
  // carry has been flushed too. ROR repeats every 32 steps.
  localparam int SHIFT_MAX_STEPS = 33;
  localparam int ROR_PERIOD      = 32;
  localparam int STEP_W          = 6;

  typedef logic [STEP_W-1:0] step_cnt_t;

  // Unused codes 110/111 behave as LSL.
  function automatic shift_type_e decode_shift_type(input logic [2:0] code);
    case (code)
      3'b001:  return SH_LSR;
      3'b010:  return SH_ASR;
      3'b011:  return SH_ROR;
      3'b100:  return SH_RRX;
      3'b101:  return SH_IMM_ROT;
      default: return SH_LSL;
    endcase
  endfunction

endpackage

// File: rtl/operand_shifter_if.sv
// Request/response bundle between the execute-stage controller (master)
// and the operand shifter (slave).
interface operand_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) ();
  logic             start;
  logic [2:0]       shift_type;
  logic [WIDTH-1:0] value;
  logic [AMT_W-1:0] amount;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             shifter_carry;

  modport master (
    output start, shift_type, value, amount, carry_in,
    input  busy, done, result, shifter_carry
  );

  modport slave (
    input  start, shift_type, value, amount, carry_in,
    output busy, done, result, shifter_carry
  );
endinterface

// File: rtl/operand_shifter_shift_step.sv
// shift_step: one bit-position of LSL/LSR/ASR/ROR/RRX with ARM carry-out.
// Purely combinational; used singly (iterative) or chained (fast build).
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  shift_type_e      shift_type,
  input  logic [WIDTH-1:0] data,
  input  logic             sign,
  input  logic             rrx_fill,
  output logic [WIDTH-1:0] next_data,
  output logic             carry_out
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    next_data = data;
    carry_out = data[0];
    case (shift_type)
      SH_LSR:             next_data = {1'b0, data[WIDTH-1:1]};
      SH_ASR:             next_data = {sign, data[WIDTH-1:1]};
      SH_ROR, SH_IMM_ROT: next_data = {data[0], data[WIDTH-1:1]};
      SH_RRX:             next_data = {rrx_fill, data[WIDTH-1:1]};
      default: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        carry_out = data[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/operand_shifter.sv
// operand_shifter: ARM-style operand-B shifter with start/done handshake.
// Default build shifts one bit per clock; define OPERAND_SHIFTER_FAST_EN
// to compute the whole shift in the accept cycle with a chained barrel.
module operand_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic clk,
  input  logic reset,
  operand_shifter_if.slave bus
);

  state_e           state;
  shift_type_e      req_type;
  step_cnt_t        req_steps;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  assign bus.result        = result_q;
  assign bus.shifter_carry = carry_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

  // Step count N for the request presented on the bus this cycle.
  always_comb begin
    req_type  = decode_shift_type(bus.shift_type);
    req_steps = '0;
    case (req_type)
      SH_ROR: begin
        if (bus.amount[4:0] == 5'd0 && bus.amount != '0)
          req_steps = STEP_W'(ROR_PERIOD);
        else
          req_steps = STEP_W'(bus.amount[4:0]);
      end
      SH_RRX:     req_steps = STEP_W'(1);
      SH_IMM_ROT: req_steps = STEP_W'({bus.amount[3:0], 1'b0});
      default: begin
        if (bus.amount > AMT_W'(SHIFT_MAX_STEPS))
          req_steps = STEP_W'(SHIFT_MAX_STEPS);
        else
          req_steps = STEP_W'(bus.amount);
      end
    endcase
  end

`ifdef OPERAND_SHIFTER_FAST_EN

  // Stage i holds the operand after i single-bit steps; the request's N
  // selects the tap, so results match the iterative build bit for bit.
  logic [WIDTH-1:0] stage_data  [SHIFT_MAX_STEPS+1];
  logic             stage_carry [SHIFT_MAX_STEPS+1];

  assign stage_data[0]  = bus.value;
  assign stage_carry[0] = bus.carry_in;

  for (genvar i = 0; i < SHIFT_MAX_STEPS; i++) begin : g_chain
    shift_step #(.WIDTH(WIDTH)) u_step (
      .shift_type (req_type),
      .data       (stage_data[i]),
      .sign       (stage_data[i][WIDTH-1]),
      .rrx_fill   (stage_carry[i]),
      .next_data  (stage_data[i+1]),
      .carry_out  (stage_carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (reset) begin
      state    <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            result_q <= stage_data[req_steps];
            carry_q  <= stage_carry[req_steps];
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`else

  shift_type_e      type_q;
  step_cnt_t        count_q;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // The working register doubles as the result. RRX is always one step,
  // so the latched carry_in is still in carry_q when it is needed as fill.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .shift_type (type_q),
    .data       (result_q),
    .sign       (result_q[WIDTH-1]),
    .rrx_fill   (carry_q),
    .next_data  (step_data),
    .carry_out  (step_carry)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (reset) begin
      state    <= ST_IDLE;
      type_q   <= SH_LSL;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            type_q   <= req_type;
            count_q  <= req_steps;
            result_q <= bus.value;
            carry_q  <= bus.carry_in;
            if (req_steps != '0) begin
              state  <= ST_SHIFT;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          result_q <= step_data;
          carry_q  <= step_carry;
          count_q  <= count_q - STEP_W'(1);
          if (count_q == STEP_W'(1)) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_operand_shifter.sv
// Directed self-checking bench for operand_shifter; expected values are
// hand-computed. Latency expectations follow OPERAND_SHIFTER_FAST_EN.
module tb_operand_shifter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  operand_shifter_if #(.WIDTH(32), .AMT_W(8)) bus ();

  operand_shifter #(.WIDTH(32), .AMT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef OPERAND_SHIFTER_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input int n);
    return FAST ? 1 : n + 1;
  endfunction

  // Waits (bounded) for done; k = cycles after the accept edge, 1 = T+1.
  task automatic wait_done(output int k);
    k = 1;
    while (bus.done !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] st, input logic [31:0] v,
                        input logic [7:0] a, input logic c,
                        input logic [31:0] er, input logic ec, input int n);
    int k;
    @(negedge clk);
    bus.shift_type = st;
    bus.value      = v;
    bus.amount     = a;
    bus.carry_in   = c;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.value      = 32'hDEAD_BEEF;
    bus.amount     = 8'hFF;
    bus.carry_in   = ~c;
    bus.shift_type = 3'b010;
    check({tag, ".busy1"}, 64'(bus.busy), 64'(!FAST && n > 0));
    wait_done(k);
    check({tag, ".lat"}, 64'(k), 64'(exp_latency(n)));
    check({tag, ".res"}, 64'(bus.result), 64'(er));
    check({tag, ".cy"}, 64'(bus.shifter_carry), 64'(ec));
    check({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int k1;
    int k2;
    int dones;

    bus.start      = 1'b0;
    bus.shift_type = 3'b000;
    bus.value      = '0;
    bus.amount     = '0;
    bus.carry_in   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.res",  64'(bus.result), 64'd0);
    check("rst.cy",   64'(bus.shifter_carry), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    //     tag         type    value          amt    cin   result         cy    N
    run_op("lsl1",    3'b000, 32'h8000_0001, 8'd1,  1'b0, 32'h0000_0002, 1'b1, 1);
    run_op("asr40",   3'b010, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
    run_op("ror4",    3'b011, 32'h0000_00F1, 8'd4,  1'b0, 32'h1000_000F, 1'b0, 4);
    run_op("imm4",    3'b101, 32'h0000_00FF, 8'd4,  1'b0, 32'hFF00_0000, 1'b1, 8);
    run_op("rrx",     3'b100, 32'h0000_0003, 8'd9,  1'b1, 32'h8000_0001, 1'b1, 1);
    run_op("lsl0",    3'b000, 32'h1234_5678, 8'd0,  1'b1, 32'h1234_5678, 1'b1, 0);
    run_op("lsl32",   3'b000, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 32);
    run_op("lsr32",   3'b001, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 32);
    run_op("lsr40",   3'b001, 32'hFFFF_FFFF, 8'd40, 1'b1, 32'h0000_0000, 1'b0, 33);
    run_op("ror32",   3'b011, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b1, 32);
    run_op("ror64",   3'b011, 32'h8000_0001, 8'd64, 1'b0, 32'h8000_0001, 1'b1, 32);
    run_op("ror0",    3'b011, 32'h0000_0005, 8'd0,  1'b0, 32'h0000_0005, 1'b0, 0);
    run_op("lsr4",    3'b001, 32'h0000_00F0, 8'd4,  1'b1, 32'h0000_000F, 1'b0, 4);
    run_op("asr4",    3'b010, 32'h8000_0008, 8'd4,  1'b0, 32'hF800_0000, 1'b1, 4);
    run_op("t111",    3'b111, 32'h0000_0001, 8'd3,  1'b1, 32'h0000_0008, 1'b0, 3);
    run_op("immF1",   3'b101, 32'h0000_0001, 8'hF1, 1'b0, 32'h4000_0000, 1'b0, 2);

    // Back-to-back: start held through DONE; second request is LSR 0x84 by 3.
    @(negedge clk);
    bus.shift_type = 3'b000;
    bus.value      = 32'h0000_0001;
    bus.amount     = 8'd2;
    bus.carry_in   = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.shift_type = 3'b001;
    bus.value      = 32'h0000_0084;
    bus.amount     = 8'd3;
    bus.carry_in   = 1'b0;
    wait_done(k1);
    check("b2b.lat1", 64'(k1), 64'(exp_latency(2)));
    check("b2b.res1", 64'(bus.result), 64'h4);
    check("b2b.cy1",  64'(bus.shifter_carry), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(k2);
    check("b2b.lat2", 64'(k2), 64'(exp_latency(3)));
    check("b2b.res2", 64'(bus.result), 64'h10);
    check("b2b.cy2",  64'(bus.shifter_carry), 64'd1);

`ifndef OPERAND_SHIFTER_FAST_EN
    // Abort: LSR by 20, stray start in SHIFT, reset during cycle T+5.
    @(negedge clk);
    bus.shift_type = 3'b001;
    bus.value      = 32'hFFFF_FFFF;
    bus.amount     = 8'd20;
    bus.carry_in   = 1'b1;
    bus.start      = 1'b1;
    @(posedge clk); #1;            // cycle T+1
    bus.start  = 1'b0;
    @(posedge clk); #1;            // cycle T+2
    bus.amount = 8'd0;
    bus.start  = 1'b1;
    @(posedge clk); #1;            // cycle T+3
    bus.start  = 1'b0;
    check("abort.ign_busy", 64'(bus.busy), 64'd1);
    check("abort.ign_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;            // cycle T+4
    @(posedge clk); #1;            // cycle T+5
    reset = 1'b1;
    @(posedge clk); #1;            // cycle T+6
    reset = 1'b0;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.res",  64'(bus.result), 64'd0);
    check("abort.cy",   64'(bus.shifter_carry), 64'd0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check("abort.nodone", 64'(dones), 64'd0);
`else
    // Reset after a completed fast operation clears the held outputs.
    run_op("pre_rst", 3'b001, 32'hFFFF_FFFF, 8'd20, 1'b1, 32'h0000_0FFF, 1'b1, 20);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.res",  64'(bus.result), 64'd0);
    check("abort.cy",   64'(bus.shifter_carry), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
